// File: rtl/ula_seq_ctrl.sv
// ula_seq_ctrl: widens a shared 4-bit 74181-style ALU to 4*NIBBLES bits by
// stepping it one nibble per clock, LSB first, behind valid/ready handshakes.
module ula_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic [3:0]           in_s,
  input  logic                 in_m,
  input  logic                 in_cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_f,
  output logic                 out_cout,
  output logic                 out_eq,
  output logic                 busy,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_s,
  output logic                 alu_m,
  output logic                 alu_cin,
  input  logic [3:0]           alu_f,
  input  logic                 alu_aeqb,
  input  logic                 alu_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_f;
  logic [3:0]      r_s;
  logic            r_m;
  logic            r_carry;
  logic            r_eq;
  logic            r_inReady;
  logic            r_outValid;
  logic            r_busy;

  // Handshake flags are registered next to the state so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_f        <= '0;
      r_s        <= '0;
      r_m        <= 1'b0;
      r_carry    <= 1'b0;
      r_eq       <= 1'b0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_inReady) begin
            r_a       <= in_a;
            r_b       <= in_b;
            r_s       <= in_s;
            r_m       <= in_m;
            r_carry   <= in_cin;
            r_eq      <= 1'b1;
            r_f       <= '0;
            r_idx     <= '0;
            r_state   <= RUN;
            r_inReady <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        RUN: begin
          for (int k = 0; k < NIBBLES; k++) begin
            if (r_idx == IW'(k)) r_f[4*k +: 4] <= alu_f;
          end
          r_carry <= alu_cout;
          r_eq    <= r_eq & alu_aeqb;
          if (r_idx == IW'(NIBBLES - 1)) begin
            r_state    <= DONE;
            r_outValid <= 1'b1;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state    <= IDLE;
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
            r_inReady  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The shared ALU sees the current nibble only while running; otherwise all zeros.
  always_comb begin
    alu_a   = 4'h0;
    alu_b   = 4'h0;
    alu_s   = 4'h0;
    alu_m   = 1'b0;
    alu_cin = 1'b0;
    if (r_state == RUN) begin
      for (int k = 0; k < NIBBLES; k++) begin
        if (r_idx == IW'(k)) begin
          alu_a = r_a[4*k +: 4];
          alu_b = r_b[4*k +: 4];
        end
      end
      alu_s   = r_s;
      alu_m   = r_m;
      alu_cin = r_carry;
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign busy      = r_busy;
  assign out_f     = r_f;
  assign out_cout  = r_outValid & r_carry;
  assign out_eq    = r_outValid & r_eq;

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// tb_ula_seq_ctrl: drives ula_seq_ctrl against a behavioural 74181 and checks
// results, timing, backpressure and reset against a whole-operation reference.
module tb_ula_seq_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [3:0]   in_s = '0;
  logic         in_m = 1'b0;
  logic         in_cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_f;
  logic         out_cout;
  logic         out_eq;
  logic         busy;
  logic [3:0]   alu_a, alu_b, alu_s, alu_f;
  logic         alu_m, alu_cin, alu_aeqb, alu_cout;
  logic [4:0]   aluRes;

  int checks = 0;
  int errors = 0;

  logic [3:0] recA   [N];
  logic [3:0] recB   [N];
  logic [4:0] recSM  [N];
  logic       recCin [N];
  int         lat;

  always #5 clk = ~clk;

  ula_seq_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_s(in_s), .in_m(in_m), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_f(out_f), .out_cout(out_cout), .out_eq(out_eq), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_aeqb(alu_aeqb), .alu_cout(alu_cout)
  );

  // 74181 with active-high data and active-high carry: returns {cout, f}.
  function automatic logic [4:0] alu74181(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] s, input logic m, input logic c);
    logic [3:0] x, y, lf;
    logic [4:0] sum;
    x = a; y = 4'h0; lf = 4'h0;
    case (s)
      4'd0:  begin x = a;       y = 4'h0;   lf = ~a;       end
      4'd1:  begin x = a | b;   y = 4'h0;   lf = ~(a | b); end
      4'd2:  begin x = a | ~b;  y = 4'h0;   lf = ~a & b;   end
      4'd3:  begin x = 4'h0;    y = 4'hF;   lf = 4'h0;     end
      4'd4:  begin x = a;       y = a & ~b; lf = ~(a & b); end
      4'd5:  begin x = a | b;   y = a & ~b; lf = ~b;       end
      4'd6:  begin x = a;       y = ~b;     lf = a ^ b;    end
      4'd7:  begin x = a & ~b;  y = 4'hF;   lf = a & ~b;   end
      4'd8:  begin x = a;       y = a & b;  lf = ~a | b;   end
      4'd9:  begin x = a;       y = b;      lf = ~(a ^ b); end
      4'd10: begin x = a | ~b;  y = a & b;  lf = b;        end
      4'd11: begin x = a & b;   y = 4'hF;   lf = a & b;    end
      4'd12: begin x = a;       y = a;      lf = 4'hF;     end
      4'd13: begin x = a | b;   y = a;      lf = a | ~b;   end
      4'd14: begin x = a | ~b;  y = a;      lf = a | b;    end
      default: begin x = a;     y = 4'hF;   lf = a;        end
    endcase
    sum = {1'b0, x} + {1'b0, y} + {4'b0, c};
    return {sum[4], m ? lf : sum[3:0]};
  endfunction

  assign aluRes   = alu74181(alu_a, alu_b, alu_s, alu_m, alu_cin);
  assign alu_f    = aluRes[3:0];
  assign alu_cout = aluRes[4];
  assign alu_aeqb = (aluRes[3:0] == 4'hF);

  // Whole-width reference: the nibble ALU applied LSB first with the carry chained.
  function automatic logic [W+1:0] refOp(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] s, input logic m, input logic cin);
    logic [W-1:0] f;
    logic c, eq;
    logic [4:0] r;
    f = '0; c = cin; eq = 1'b1;
    for (int k = 0; k < N; k++) begin
      r = alu74181(a[4*k +: 4], b[4*k +: 4], s, m, c);
      f[4*k +: 4] = r[3:0];
      c = r[4];
      eq = eq & (r[3:0] == 4'hF);
    end
    return {eq, c, f};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for out_valid, recording the ALU drive per nibble.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [3:0] s, input logic m, input logic cin);
    in_a = a; in_b = b; in_s = s; in_m = m; in_cin = cin;
    out_ready = 1'b0;
    checkOutput("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 4 * N + 4) begin
      if (lat < N) begin
        recA[lat]   = alu_a;
        recB[lat]   = alu_b;
        recSM[lat]  = {alu_s, alu_m};
        recCin[lat] = alu_cin;
      end
      tick();
      lat++;
    end
    checkOutput("latency", lat, N);
    for (int k = 0; k < N; k++) begin
      checkOutput($sformatf("alu_a[%0d]", k), recA[k], a[4*k +: 4]);
      checkOutput($sformatf("alu_b[%0d]", k), recB[k], b[4*k +: 4]);
      checkOutput($sformatf("alu_sm[%0d]", k), recSM[k], {s, m});
    end
  endtask

  // Hold the result for bp cycles (poking in_valid/in_a to prove they are ignored), then release.
  task automatic releaseResult(input int bp);
    logic [W-1:0] hf;
    logic hc, he;
    hf = out_f; hc = out_cout; he = out_eq;
    for (int i = 0; i < bp; i++) begin
      in_valid = i[0];
      in_a = W'($urandom);
      tick();
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_busy", busy, 1);
      checkOutput("bp_out_f", out_f, hf);
      checkOutput("bp_out_cout_eq", {out_cout, out_eq}, {hc, he});
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    checkOutput("release_out_valid", out_valid, 0);
    checkOutput("release_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [W+1:0] exp;
    logic [W:0]   sum;
    logic [W-1:0] ra, rb;
    logic [3:0]   rs;
    logic         rm, rc, sawValid;
    logic [3:0]   expA   [N];
    logic         expCin [N];

    // Reset values.
    rst = 1'b1;
    tick();
    tick();
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_out_f", out_f, 0);
    checkOutput("rst_cout_eq", {out_cout, out_eq}, 0);
    checkOutput("rst_alu", {alu_a, alu_b, alu_s, alu_m, alu_cin}, 0);
    rst = 1'b0;

    // Logic XOR.
    applyStimulus(16'hF0A5, 16'h0FFF, 4'b0110, 1'b1, 1'b0);
    checkOutput("xor_out_f", out_f, 16'hFF5A);
    checkOutput("xor_busy", busy, 1);
    expA[0] = 4'h5; expA[1] = 4'hA; expA[2] = 4'h0; expA[3] = 4'hF;
    for (int k = 0; k < N; k++) checkOutput($sformatf("xor_seq[%0d]", k), recA[k], expA[k]);
    releaseResult(0);

    // Arithmetic add with ripple.
    applyStimulus(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0);
    checkOutput("add_out_f", out_f, 16'h0100);
    checkOutput("add_out_cout", out_cout, 0);
    expCin[0] = 1'b0; expCin[1] = 1'b1; expCin[2] = 1'b1; expCin[3] = 1'b0;
    for (int k = 0; k < N; k++) checkOutput($sformatf("add_cin[%0d]", k), recCin[k], expCin[k]);
    releaseResult(0);

    // Overflow.
    applyStimulus(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0);
    checkOutput("ovf_out_f", out_f, 16'h0000);
    checkOutput("ovf_out_cout", out_cout, 1);
    releaseResult(0);

    // Equality: A minus B minus 1 is all ones exactly when A == B.
    applyStimulus(16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b0);
    checkOutput("eq_same_out_eq", out_eq, 1);
    checkOutput("eq_same_out_f", out_f, 16'hFFFF);
    releaseResult(0);
    applyStimulus(16'h1234, 16'h1235, 4'b0110, 1'b0, 1'b0);
    checkOutput("eq_diff_out_eq", out_eq, 0);
    checkOutput("eq_diff_out_f", out_f, 16'hFFFE);
    releaseResult(0);

    // Backpressure with in_valid toggling while DONE is held.
    applyStimulus(16'h1357, 16'h2468, 4'b1001, 1'b0, 1'b1);
    checkOutput("bp_sum", out_f, 16'h37C0);
    releaseResult(5);
    tick();
    checkOutput("bp_no_new_op", busy, 0);

    // Reset in the middle of RUN at idx 2.
    in_a = 16'hABCD; in_b = 16'h1111; in_s = 4'b1001; in_m = 1'b0; in_cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checkOutput("midrst_alu_a_idx2", alu_a, 4'hB);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_out_f", out_f, 0);
    checkOutput("midrst_alu_a", alu_a, 0);
    sawValid = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      tick();
      if (out_valid === 1'b1) sawValid = 1'b1;
    end
    checkOutput("midrst_no_valid_pulse", sawValid, 0);
    applyStimulus(16'hABCD, 16'h1111, 4'b1001, 1'b0, 1'b0);
    checkOutput("after_rst_out_f", out_f, 16'hBCDE);
    releaseResult(0);

    // Reset wins over a simultaneous handshake.
    in_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    checkOutput("rst_vs_hs_busy", busy, 0);
    checkOutput("rst_vs_hs_in_ready", in_ready, 1);

    // Randomized operations against the reference model.
    for (int t = 0; t < 24; t++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 4'($urandom);
      rm = 1'($urandom);
      rc = 1'($urandom);
      if (t < 6) begin
        rs = 4'b1001;
        rm = 1'b0;
      end
      exp = refOp(ra, rb, rs, rm, rc);
      applyStimulus(ra, rb, rs, rm, rc);
      checkOutput("rand_out_f", out_f, exp[W-1:0]);
      checkOutput("rand_out_cout", out_cout, exp[W]);
      checkOutput("rand_out_eq", out_eq, exp[W+1]);
      if (rs == 4'b1001 && !rm) begin
        sum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
        checkOutput("rand_add_width", {out_cout, out_f}, sum);
      end
      if (rs == 4'b0110 && rm) checkOutput("rand_xor_width", out_f, ra ^ rb);
      releaseResult($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_seq_ctrl.md
# ula_seq_ctrl

Multi-nibble sequencer that widens the combinational 4-bit `ula_74181` into a 4·NIBBLES-bit ALU operation. It time-multiplexes a single external `ula_74181` instance, one nibble per clock, least-significant nibble first. It chains the ALU carry through a register between nibbles and assembles the full-width result. Operands are taken and results returned over valid/ready handshakes, so the block sits between a requester (register file, test driver) and the shared ALU.

## Interface
- `NIBBLES`, default 4: operand width is 4·NIBBLES bits; legal range 2..8.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept a request (high only in IDLE).
- `in_a`, `in_b`  in  4·NIBBLES  operands.
- `in_s`  in  4  ALU function select, passed unchanged to the ALU.
- `in_m`  in  1  mode: 1 = logic, 0 = arithmetic.
- `in_cin`  in  1  carry into nibble 0, same polarity as `ula_74181` `c_in` (1 = carry asserted).
- `out_valid`  out  1  result available (DONE state).
- `out_ready`  in  1  consumer accepts the result.
- `out_f`  out  4·NIBBLES  assembled result.
- `out_cout`  out  1  carry out of the last nibble.
- `out_eq`  out  1  AND of `a_eq_b` over all nibbles.
- `busy`  out  1  high in RUN or DONE.
- `alu_a`, `alu_b`, `alu_s`  out  4  to ALU `a`, `b`, `s`.
- `alu_m`, `alu_cin`  out  1  to ALU `m`, `c_in`.
- `alu_f`  in  4  from ALU `f`.
- `alu_aeqb`, `alu_cout`  in  1  from ALU `a_eq_b`, `c_out`.

## Operation
- States: IDLE, RUN, DONE. Nibble index `idx` has width clog2(NIBBLES).
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`:
  - latch `in_a`, `in_b`, `in_s`, `in_m`;
  - set the carry register to `in_cin` and the eq register to 1;
  - clear `out_f`; set `idx`=0; go to RUN.
- RUN, combinational drive while in this state:
  - `alu_a`=a_reg[4·idx+3:4·idx], `alu_b`=b_reg[4·idx+3:4·idx];
  - `alu_s`=s_reg, `alu_m`=m_reg, `alu_cin`=carry register.
- RUN, on each edge:
  - capture `alu_f` into `out_f`[4·idx+3:4·idx];
  - carry register ← `alu_cout`;
  - eq register ← eq register & `alu_aeqb`;
  - if `idx`==NIBBLES-1, go to DONE; otherwise increment `idx`.
- DONE: `out_valid`=1, `out_cout`=carry register, `out_eq`=eq register.
  - `out_f`, `out_cout` and `out_eq` hold stable while `out_valid` is high.
  - On `out_ready`, go to IDLE.
- The carry is chained in both modes. In logic mode the ALU ignores `c_in`, and `out_cout` reports whatever `alu_cout` the last nibble produced.
- Outside RUN, all `alu_*` outputs are driven to 0.
- No request overlap: `in_ready`=0 in RUN and DONE; `in_valid` in those states is ignored.

## Timing
- Reset values:
  - state=IDLE, `idx`=0, all registers 0;
  - `in_ready`=1, `out_valid`=0, `busy`=0;
  - `out_f`=0, `out_cout`=0, `out_eq`=0, `alu_*`=0.
- Latency: accept on edge E0 → nibble k computed in the cycle after E(k) and captured at E(k+1). `out_valid` rises after edge E(NIBBLES), i.e. 4 cycles for the default.
- Back-to-back operation:
  - `out_ready` held high → DONE lasts 1 cycle;
  - IDLE returns on the next edge;
  - the next request can be accepted 1 cycle later.
- Minimum period per operation is NIBBLES+2 cycles.
- `out_ready` low: DONE is held indefinitely with outputs stable.
- `rst` in any state (including mid-RUN) takes effect on that edge and restores all reset values. The partial result is discarded; no `out_valid` pulse occurs.
- Simultaneous `rst` and handshake: reset wins.

## Test plan
- Reset mid-RUN:
  - stimulus: accept a request, assert `rst` at `idx`=2;
  - required: next cycle `in_ready`=1, `out_valid`=0, `out_f`=0, `alu_a`=0; a request issued afterwards completes normally.
- Logic XOR:
  - stimulus: M=1, S=0110, A=0xF0A5, B=0x0FFF;
  - required: `out_f`=0xFF5A; `out_valid` exactly 4 cycles after the accept edge; `alu_a` sequence 5, A, 0, F.
- Arithmetic add with carry ripple:
  - stimulus: M=0, S=1001 (A plus B), A=0x00FF, B=0x0001, cin=0;
  - required: `out_f`=0x0100, `out_cout`=0; `alu_cin` per nibble is 0, 1, 1, 0.
- Overflow:
  - stimulus: M=0, S=1001, A=0xFFFF, B=0x0001, cin=0;
  - required: `out_f`=0x0000, `out_cout`=1.
- Backpressure and busy-ignore:
  - stimulus: hold `out_ready`=0 for 5 cycles in DONE, toggling `in_valid`;
  - required: `out_f` and `out_valid` stable, `in_ready`=0, no new operation starts; the result is released on the first `out_ready`=1.
- Equality:
  - stimulus: M=0, S=0110 (A minus B minus 1), cin=0, A=B=0x1234;
  - required: `out_eq`=1.
  - stimulus: repeat with B=0x1235;
  - required: `out_eq`=0.
